dmem_arb: RTL and testbench
===========================

DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data and address width.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive debug-grant cycles while the CPU is waiting (range 1..255).
REQ-003 The block SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU requests the data memory.
- cpu_we  in  1  CPU write strobe.
- cpu_addr  in  WIDTH  CPU address.
- cpu_wdata  in  WIDTH  CPU write data.
- cpu_gnt  out  1  CPU owns the memory.
- dbg_req  in  1  debug/loader port requests the data memory.
- dbg_we  in  1  debug write strobe.
- dbg_addr  in  WIDTH  debug address.
- dbg_wdata  in  WIDTH  debug write data.
- dbg_gnt  out  1  debug port owns the memory.
- mem_addr  out  WIDTH  address to the data memory.
- mem_wdata  out  WIDTH  write data to the data memory.
- mem_en  out  1  write enable to the data memory.
- stall  out  1  holds the CPU program counter.

Function
REQ-004 The arbiter SHALL be an FSM with states IDLE, CPU and DBG; cpu_gnt SHALL be 1 only in CPU, and dbg_gnt SHALL be 1 only in DBG.
REQ-005 Grant latency: a request sampled at edge N SHALL produce its grant after edge N (registered); there SHALL be no combinational req-to-gnt path.
REQ-006 In IDLE:
- cpu_req only -> CPU.
- dbg_req only -> DBG.
- both -> the requester not recorded in last_served.
- neither -> remain in IDLE.
REQ-007 In CPU, the grant SHALL hold while cpu_req=1. On cpu_req=0 the FSM SHALL go to DBG if dbg_req=1, else to IDLE, with no idle bubble.
REQ-008 In DBG, on dbg_req=0 the FSM SHALL go to CPU if cpu_req=1, else to IDLE.
REQ-009 last_served SHALL update to the owner on every entry into CPU or DBG.
REQ-010 mem_addr and mem_wdata SHALL combinationally mux the granted requester's inputs and SHALL be 0 in IDLE.
REQ-011 mem_en SHALL equal gnt AND req AND we of the owner. A write SHALL NOT be issued in the cycle the owner has dropped req but still holds the grant.
REQ-012 stall SHALL equal cpu_req AND NOT cpu_gnt (combinational).
REQ-013 Simultaneous cpu_req drop and dbg_req rise in state CPU SHALL hand over to DBG at the next edge.

Reset
REQ-014 When rst=0 at a rising edge, the block SHALL set: state=IDLE, cpu_gnt=0, dbg_gnt=0, last_served=DBG (so the CPU wins the first tie), burst_cnt=0.
REQ-015 During and after reset: mem_en=0 and mem_addr=0. stall SHALL follow REQ-012.
REQ-016 A reset asserted mid-grant SHALL abort ownership at that edge with no further mem_en.

Configuration
REQ-017 With macro DMEM_ARB_STARVE_GUARD_EN defined, the block SHALL implement an 8-bit burst_cnt with the following behaviour:
- In DBG with cpu_req=1, burst_cnt SHALL increment each cycle.
- When burst_cnt=MAX_BURST-1 and cpu_req=1, the FSM SHALL go to CPU regardless of dbg_req.
- burst_cnt SHALL clear on leaving DBG or when cpu_req=0.
- The CPU SHALL then hold per REQ-007.
REQ-018 Without the macro, burst_cnt SHALL be absent, and DBG SHALL hold until dbg_req=0. MAX_BURST SHALL be ignored.

Verification
REQ-019 Reset then both req=1 at same edge -> cpu_gnt=1 next cycle, dbg_gnt=0, stall=0.
REQ-020 CPU owns with cpu_we=1, addr=0x12, wdata=0xA5 -> mem_addr=0x12, mem_wdata=0xA5, mem_en=1. cpu_req drops with dbg_req=1 -> dbg_gnt=1 next cycle, mem_en=0 in the drop cycle.
REQ-021 Guard enabled, MAX_BURST=4, dbg holds req, cpu_req raised -> dbg_gnt for exactly 4 cycles with stall=1, then cpu_gnt=1.
REQ-022 Guard disabled, same stimulus for 20 cycles -> dbg_gnt stays 1 and stall stays 1 until dbg_req=0, then cpu_gnt=1 next cycle.
REQ-023 rst=0 while dbg_gnt=1 with dbg_we=1 -> after that edge dbg_gnt=0, mem_en=0. With rst=1 and both req=1 -> cpu_gnt=1 (tie to CPU).
REQ-024 Alternating ties from IDLE, with requests dropped between each -> grants alternate CPU, DBG, CPU.

Source files
------------

// File: rtl/dmem_arb.sv
// Two-port data-memory arbiter (CPU vs debug/loader) with registered grants.
// Optional debug-burst starvation guard: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arb #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_gnt,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [WIDTH-1:0] dbg_addr,
    input  logic [WIDTH-1:0] dbg_wdata,
    output logic             dbg_gnt,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_en,
    output logic             stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        DBG  = 2'd2
    } state_t;

    state_t state, state_nxt;
    state_t last_served, last_served_nxt;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("dmem_arb: MAX_BURST must be in 1..255");
    end

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    logic [7:0] burst_cnt, burst_cnt_nxt;
    logic       burst_hit;

    assign burst_hit = cpu_req && (burst_cnt == BURST_LAST);
`endif

    // Next-state: grants only ever change at the clock edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_req && dbg_req)
                    state_nxt = (last_served == CPU) ? DBG : CPU;
                else if (cpu_req)
                    state_nxt = CPU;
                else if (dbg_req)
                    state_nxt = DBG;
            end
            CPU: begin
                if (!cpu_req)
                    state_nxt = dbg_req ? DBG : IDLE;
            end
            DBG: begin
                if (!dbg_req)
                    state_nxt = cpu_req ? CPU : IDLE;
`ifdef DMEM_ARB_STARVE_GUARD_EN
                if (burst_hit)
                    state_nxt = CPU;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        last_served_nxt = last_served;
        if (state_nxt != IDLE && state_nxt != state)
            last_served_nxt = state_nxt;
    end

`ifdef DMEM_ARB_STARVE_GUARD_EN
    // Counts cycles the CPU has waited behind a debug owner that keeps the grant.
    always_comb begin
        burst_cnt_nxt = 8'd0;
        if (state == DBG && state_nxt == DBG && cpu_req)
            burst_cnt_nxt = burst_cnt + 8'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            last_served <= DBG;
`ifdef DMEM_ARB_STARVE_GUARD_EN
            burst_cnt   <= 8'd0;
`endif
        end else begin
            state       <= state_nxt;
            last_served <= last_served_nxt;
`ifdef DMEM_ARB_STARVE_GUARD_EN
            burst_cnt   <= burst_cnt_nxt;
`endif
        end
    end

    assign cpu_gnt = (state == CPU);
    assign dbg_gnt = (state == DBG);
    assign stall   = cpu_req & ~cpu_gnt;

    // Reset gates the memory side immediately so no write slips out while rst is low.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_en    = 1'b0;
        if (rst) begin
            case (state)
                CPU: begin
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    mem_en    = cpu_req & cpu_we;
                end
                DBG: begin
                    mem_addr  = dbg_addr;
                    mem_wdata = dbg_wdata;
                    mem_en    = dbg_req & dbg_we;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Scoreboard bench for dmem_arb: per-cycle expected outputs from an ownership model.
module tb_dmem_arb;
    localparam int W  = 8;
    localparam int MB = 4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
    logic [W-1:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
    logic cpu_gnt, dbg_gnt, mem_en, stall;
    logic [W-1:0] mem_addr, mem_wdata;

    always #5 clk = ~clk;

    dmem_arb #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .stall(stall)
    );

    typedef struct {
        int           tag;
        logic         cg, dg, en, st;
        logic [W-1:0] a, w;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Owner: 0 nobody, 1 CPU, 2 debug. last_win starts at debug so the CPU wins the first tie.
    int owner = 0;
    int last_win = 2;
    int cpu_wait = 0;

    task automatic cyc(input int tag, input logic r, input logic c, input logic cw,
                       input logic [W-1:0] ca, input logic [W-1:0] cd,
                       input logic d, input logic dw,
                       input logic [W-1:0] da, input logic [W-1:0] dd);
        exp_t e;
        int nxt;
        @(posedge clk);
        #2;
        rst = r; cpu_req = c; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = d; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        e.tag = tag;
        e.cg  = (owner == 1);
        e.dg  = (owner == 2);
        e.st  = c && (owner != 1);
        e.a   = '0; e.w = '0; e.en = 1'b0;
        if (r && owner == 1) begin e.a = ca; e.w = cd; e.en = c && cw; end
        if (r && owner == 2) begin e.a = da; e.w = dd; e.en = d && dw; end
        q.push_back(e);
        // Ownership after the coming edge.
        if (!r) begin
            owner = 0; last_win = 2; cpu_wait = 0;
        end else begin
            nxt = owner;
            if (owner == 0) begin
                if (c && d) nxt = (last_win == 1) ? 2 : 1;
                else if (c) nxt = 1;
                else if (d) nxt = 2;
            end else if (owner == 1) begin
                if (!c) nxt = d ? 2 : 0;
            end else begin
                if (GUARD && c && cpu_wait == MB - 1) nxt = 1;
                else if (!d) nxt = c ? 1 : 0;
            end
            cpu_wait = (owner == 2 && nxt == 2 && c) ? cpu_wait + 1 : 0;
            if (nxt != 0 && nxt != owner) last_win = nxt;
            owner = nxt;
        end
    endtask

    task automatic idle_cyc(input int tag, input logic r);
        cyc(tag, r, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    // Monitor: compares whatever the DUT shows each cycle against the oldest expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #4;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (cpu_gnt !== e.cg || dbg_gnt !== e.dg || mem_en !== e.en || stall !== e.st ||
                mem_addr !== e.a || mem_wdata !== e.w) begin
                errors++;
                $display("FAIL tag%0d t=%0t: got cg=%b dg=%b en=%b st=%b a=%h w=%h want cg=%b dg=%b en=%b st=%b a=%h w=%h",
                         e.tag, $time, cpu_gnt, dbg_gnt, mem_en, stall, mem_addr, mem_wdata,
                         e.cg, e.dg, e.en, e.st, e.a, e.w);
            end
        end
    end

    initial begin
        logic rc, rd;
        // Reset held with requests present: no grant, no write, stall follows cpu_req.
        @(posedge clk);
        cyc(1, 0, 1, 1, 8'h33, 8'h44, 1, 1, 8'h55, 8'h66);
        cyc(1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h55, 8'h66);
        // Tie after reset goes to CPU; CPU writes 0x12/0xA5; drop hands to debug.
        cyc(2, 1, 1, 0, 8'h00, 8'h00, 1, 0, 8'h70, 8'h71);
        cyc(2, 1, 1, 1, 8'h12, 8'hA5, 1, 0, 8'h70, 8'h71);
        cyc(2, 1, 1, 1, 8'h12, 8'hA5, 1, 1, 8'h70, 8'h71);
        cyc(2, 1, 0, 1, 8'h12, 8'hA5, 1, 1, 8'h70, 8'h71);
        cyc(2, 1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h72, 8'h73);
        // Debug holds while CPU waits: burst guard or indefinite hold.
        for (int i = 0; i < 20; i++)
            cyc(3, 1, 1, 0, 8'h01, 8'h02, 1, 1, 8'h80 + 8'(i), 8'h90);
        cyc(3, 1, 1, 0, 8'h01, 8'h02, 0, 0, 8'h00, 8'h00);
        cyc(3, 1, 1, 0, 8'h01, 8'h02, 0, 0, 8'h00, 8'h00);
        // Owner drops req while still granted: no write that cycle.
        cyc(4, 1, 0, 1, 8'h01, 8'h02, 0, 0, 8'h00, 8'h00);
        idle_cyc(4, 1);
        // Reset mid debug write, then tie goes back to CPU.
        cyc(5, 1, 0, 0, 8'h00, 8'h00, 1, 1, 8'hC0, 8'hC1);
        cyc(5, 1, 0, 0, 8'h00, 8'h00, 1, 1, 8'hC0, 8'hC1);
        cyc(5, 0, 0, 0, 8'h00, 8'h00, 1, 1, 8'hC0, 8'hC1);
        cyc(5, 1, 0, 0, 8'h00, 8'h00, 1, 1, 8'hC0, 8'hC1);
        cyc(5, 1, 1, 1, 8'hD0, 8'hD1, 1, 1, 8'hC0, 8'hC1);
        cyc(5, 1, 1, 1, 8'hD0, 8'hD1, 1, 1, 8'hC0, 8'hC1);
        // Alternating ties from IDLE with both requests dropped in between.
        idle_cyc(6, 1);
        idle_cyc(6, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(6, 1, 1, 0, 8'h10, 8'h11, 1, 0, 8'h20, 8'h21);
            idle_cyc(6, 1);
            idle_cyc(6, 1);
        end
        // Randomized traffic with sticky requests and rare resets.
        rc = 0; rd = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rc = ~rc;
            if ($urandom_range(0, 4) == 0) rd = ~rd;
            cyc(7, ($urandom_range(0, 63) != 0), rc, 1'($urandom), 8'($urandom), 8'($urandom),
                rd, 1'($urandom), 8'($urandom), 8'($urandom));
        end
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
